// File: rtl/sop_acq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sop_acq_ctrl_if : control/status bundle between SOP acquisition and host
// Revision 1.0
// ============================================================================
interface sop_acq_ctrl_if;
    logic        en;
    logic        sop_raw;
    logic [23:0] thr_cfg;
    logic [23:0] thr_lvl;
    logic        sop_out;
    logic        sop_missed;
    logic        locked;
    logic [1:0]  state;
    logic [2:0]  miss_cnt;

    modport master (
        output en, sop_raw, thr_cfg,
        input  thr_lvl, sop_out, sop_missed, locked, state, miss_cnt
    );

    modport slave (
        input  en, sop_raw, thr_cfg,
        output thr_lvl, sop_out, sop_missed, locked, state, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sop_acq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sop_acq_ctrl : SEARCH/VERIFY/TRACK lock controller for the correlator SOP
// detector, with threshold control and flywheel bridging of missed SOPs.
// Revision 1.0
// ============================================================================
module sop_acq_ctrl #(
    parameter int PERIOD   = 52800,
    parameter int WIN      = 64,
    parameter int VERIFY_N = 3,
    parameter int MISS_MAX = 4,
    parameter int DWELL    = 105600,
    parameter int THR_STEP = 15,
    parameter int THR_MIN  = 30
) (
    input  wire logic       clk,
    input  wire logic       rst,
    sop_acq_ctrl_if.slave   bus
);
    localparam int PW = $clog2(PERIOD + WIN + 1);
    localparam int DW = $clog2(DWELL + 1);
    localparam int HW = $clog2(VERIFY_N + 1);

    localparam logic [PW-1:0] c_ph_lo     = PW'(PERIOD - WIN);
    localparam logic [PW-1:0] c_ph_hi     = PW'(PERIOD + WIN);
    localparam logic [PW-1:0] c_ph_centre = PW'(WIN);
    localparam logic [PW-1:0] c_ph_one    = PW'(1);
    localparam logic [DW-1:0] c_dwell_end = DW'(DWELL - 1);
    localparam logic [DW-1:0] c_dwell_one = DW'(1);
    localparam logic [HW-1:0] c_hits_lock = HW'(VERIFY_N);
    localparam logic [HW-1:0] c_hits_one  = HW'(1);
    localparam logic [2:0]    c_miss_max  = 3'(MISS_MAX);
    localparam logic [23:0]   c_thr_step  = 24'(THR_STEP);
    localparam logic [23:0]   c_thr_min   = 24'(THR_MIN);
    localparam logic [23:0]   c_thr_floor = 24'(THR_MIN + THR_STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2,
        TRACK  = 2'd3
    } state_t;

    state_t        state_q,      state_d;
    logic [23:0]   thr_q,        thr_d;
    logic [2:0]    miss_q,       miss_d;
    logic [DW-1:0] dwell_q,      dwell_d;
    logic [PW-1:0] phase_q,      phase_d;
    logic [HW-1:0] hits_q,       hits_d;
    logic          sop_out_q,    sop_out_d;
    logic          sop_missed_q, sop_missed_d;
    logic          locked_q,     locked_d;

    logic          w_in_win;
    logic [23:0]   w_thr_dec;
    logic [24:0]   w_thr_sum;
    logic [23:0]   w_thr_inc;
    logic [HW-1:0] w_hits_nxt;
    logic [2:0]    w_miss_nxt;

    assign w_in_win   = (phase_q >= c_ph_lo) && (phase_q <= c_ph_hi);
    // max(thr - step, min) without going through a negative intermediate
    assign w_thr_dec  = (thr_q >= c_thr_floor) ? (thr_q - c_thr_step) : c_thr_min;
    assign w_thr_sum  = {1'b0, thr_q} + {1'b0, c_thr_step};
    assign w_thr_inc  = w_thr_sum[24] ? 24'hFF_FFFF : w_thr_sum[23:0];
    assign w_hits_nxt = hits_q + c_hits_one;
    assign w_miss_nxt = miss_q + 3'd1;

    always_comb begin
        state_d      = state_q;
        thr_d        = thr_q;
        miss_d       = miss_q;
        dwell_d      = dwell_q;
        phase_d      = phase_q;
        hits_d       = hits_q;
        sop_out_d    = 1'b0;
        sop_missed_d = 1'b0;
        locked_d     = locked_q;

        if (state_q == IDLE) begin
            thr_d = bus.thr_cfg;
        end

        if (!bus.en) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            miss_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SEARCH;
                    dwell_d = '0;
                end
                SEARCH: begin
                    // a SOP on the dwell-terminal cycle takes priority over the step-down
                    if (bus.sop_raw) begin
                        state_d = VERIFY;
                        phase_d = '0;
                        hits_d  = '0;
                        dwell_d = '0;
                    end else if (dwell_q == c_dwell_end) begin
                        thr_d   = w_thr_dec;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + c_dwell_one;
                    end
                end
                VERIFY: begin
                    phase_d = phase_q + c_ph_one;
                    if (bus.sop_raw && w_in_win) begin
                        phase_d = '0;
                        if (w_hits_nxt == c_hits_lock) begin
                            state_d  = TRACK;
                            locked_d = 1'b1;
                            miss_d   = 3'd0;
                            hits_d   = '0;
                        end else begin
                            hits_d = w_hits_nxt;
                        end
                    end else if (bus.sop_raw) begin
                        thr_d   = w_thr_inc;
                        state_d = SEARCH;
                        dwell_d = '0;
                    end else if (phase_q == c_ph_hi) begin
                        state_d = SEARCH;
                        dwell_d = '0;
                    end
                end
                TRACK: begin
                    phase_d = phase_q + c_ph_one;
                    if (bus.sop_raw && w_in_win) begin
                        sop_out_d = 1'b1;
                        phase_d   = '0;
                        miss_d    = 3'd0;
                    end else if (phase_q == c_ph_hi) begin
                        // flywheel: pretend the SOP landed at the nominal instant
                        sop_missed_d = 1'b1;
                        phase_d      = c_ph_centre;
                        if (w_miss_nxt == c_miss_max) begin
                            state_d  = SEARCH;
                            locked_d = 1'b0;
                            thr_d    = bus.thr_cfg;
                            miss_d   = 3'd0;
                            dwell_d  = '0;
                        end else begin
                            miss_d = w_miss_nxt;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            thr_q        <= '0;
            miss_q       <= '0;
            dwell_q      <= '0;
            phase_q      <= '0;
            hits_q       <= '0;
            sop_out_q    <= 1'b0;
            sop_missed_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            thr_q        <= thr_d;
            miss_q       <= miss_d;
            dwell_q      <= dwell_d;
            phase_q      <= phase_d;
            hits_q       <= hits_d;
            sop_out_q    <= sop_out_d;
            sop_missed_q <= sop_missed_d;
            locked_q     <= locked_d;
        end
    end

    assign bus.thr_lvl    = thr_q;
    assign bus.sop_out    = sop_out_q;
    assign bus.sop_missed = sop_missed_q;
    assign bus.locked     = locked_q;
    assign bus.state      = state_q;
    assign bus.miss_cnt   = miss_q;
endmodule
`default_nettype wire

// File: tb/tb_sop_acq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sop_acq_ctrl : directed bench for sop_acq_ctrl with small test parameters
// Revision 1.0
// ============================================================================
module tb_sop_acq_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    sop_acq_ctrl_if bus ();

    sop_acq_ctrl #(
        .PERIOD   (100),
        .WIN      (4),
        .VERIFY_N (3),
        .MISS_MAX (2),
        .DWELL    (250),
        .THR_STEP (10),
        .THR_MIN  (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // wait n cycles, then present one SOP; it is sampled when phase == n
    task automatic sop_wait(input int n);
        step(n);
        bus.sop_raw = 1'b1;
        step(1);
        bus.sop_raw = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        bus.en      = 1'b0;
        bus.sop_raw = 1'b0;
        bus.thr_cfg = 24'd100;

        step(2);
        check("rst_thr", 32'(bus.thr_lvl), 0);
        check("rst_state", 32'(bus.state), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_sop_out", 32'(bus.sop_out), 0);

        rst = 1'b1;
        step(1);
        check("idle_thr", 32'(bus.thr_lvl), 100);
        check("idle_state", 32'(bus.state), 0);

        // search ramp
        bus.en = 1'b1;
        step(1);
        check("search_enter", 32'(bus.state), 1);
        step(249);
        check("ramp_pre", 32'(bus.thr_lvl), 100);
        step(1);
        check("ramp_1", 32'(bus.thr_lvl), 90);
        step(250);
        check("ramp_2", 32'(bus.thr_lvl), 80);
        step(1500);
        check("ramp_8", 32'(bus.thr_lvl), 20);
        step(250);
        check("ramp_sat", 32'(bus.thr_lvl), 20);

        // first SOP -> VERIFY, then a false alarm at phase 95
        sop_wait(0);
        check("verify_enter", 32'(bus.state), 2);
        sop_wait(95);
        check("false_state", 32'(bus.state), 1);
        check("false_thr", 32'(bus.thr_lvl), 30);

        // acquire
        sop_wait(0);
        check("reverify", 32'(bus.state), 2);
        sop_wait(99);
        sop_wait(99);
        check("hits2_state", 32'(bus.state), 2);
        sop_wait(99);
        check("lock_state", 32'(bus.state), 3);
        check("lock_locked", 32'(bus.locked), 1);
        check("lock_no_out", 32'(bus.sop_out), 0);

        // window edges in TRACK
        sop_wait(96);
        check("win96_out", 32'(bus.sop_out), 1);
        step(1);
        check("out_pulse_end", 32'(bus.sop_out), 0);
        sop_wait(103);
        check("win104_out", 32'(bus.sop_out), 1);
        sop_wait(95);
        check("win95_out", 32'(bus.sop_out), 0);
        check("win95_state", 32'(bus.state), 3);
        sop_wait(3);
        check("phase_kept", 32'(bus.sop_out), 1);

        // loss of lock, with a new thr_cfg that must wait for the loss
        bus.thr_cfg = 24'd150;
        step(104);
        check("miss_pre", 32'(bus.sop_missed), 0);
        step(1);
        check("miss1_pulse", 32'(bus.sop_missed), 1);
        check("miss1_cnt", 32'(bus.miss_cnt), 1);
        check("miss1_thr", 32'(bus.thr_lvl), 30);
        step(1);
        check("miss1_end", 32'(bus.sop_missed), 0);
        step(100);
        check("loss_state", 32'(bus.state), 1);
        check("loss_locked", 32'(bus.locked), 0);
        check("loss_thr", 32'(bus.thr_lvl), 150);
        check("loss_cnt", 32'(bus.miss_cnt), 0);

        // VERIFY timeout leaves threshold alone
        sop_wait(0);
        step(104);
        check("vto_pre", 32'(bus.state), 2);
        step(1);
        check("vto_state", 32'(bus.state), 1);
        check("vto_thr", 32'(bus.thr_lvl), 150);

        // reacquire, then drop enable
        sop_wait(0);
        sop_wait(99);
        sop_wait(99);
        sop_wait(99);
        check("relock", 32'(bus.state), 3);
        bus.thr_cfg = 24'd70;
        bus.en      = 1'b0;
        step(1);
        check("endrop_state", 32'(bus.state), 0);
        check("endrop_locked", 32'(bus.locked), 0);
        step(1);
        check("endrop_thr", 32'(bus.thr_lvl), 70);
        bus.en = 1'b1;
        step(1);
        check("reen_state", 32'(bus.state), 1);
        check("reen_thr", 32'(bus.thr_lvl), 70);

        // asynchronous reset mid-cycle
        #3;
        rst = 1'b0;
        #1;
        check("arst_thr", 32'(bus.thr_lvl), 0);
        check("arst_state", 32'(bus.state), 0);
        check("arst_locked", 32'(bus.locked), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sop_acq_ctrl.md
Name: sop_acq_ctrl

Overview:
Acquisition and tracking controller for the correlator SOP detector. It sets the detection threshold fed to the correlator and watches the raw SOP strobes. It then walks a SEARCH/VERIFY/TRACK state machine to lock onto the nominal SOP period, and delivers a gated SOP stream. Once locked, it bridges missed SOPs (flywheel) and drops back to search after repeated misses.

Parameters:
PERIOD, 52800, nominal SOP spacing in clk cycles
WIN, 64, half-width of the acceptance window around PERIOD (inclusive)
VERIFY_N, 3, consecutive in-window SOPs needed to declare lock
MISS_MAX, 4, consecutive misses in TRACK that force re-search
DWELL, 105600, cycles without a SOP in SEARCH before the threshold steps down
THR_STEP, 15, threshold adjust step
THR_MIN, 30, lower saturation limit for thr_lvl in SEARCH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  controller enable; 0 forces IDLE
sop_raw  in  1  raw SOP strobe from correlator
thr_cfg  in  24  configured start threshold
thr_lvl  out  24  threshold driven to correlator
sop_out  out  1  gated SOP pulse, TRACK only
sop_missed  out  1  one-cycle pulse on a flywheel miss
locked  out  1  high in TRACK
state  out  2  0 IDLE, 1 SEARCH, 2 VERIFY, 3 TRACK
miss_cnt  out  3  consecutive miss count

Behaviour:
- Reset (rst=0, async): state IDLE; thr_lvl, miss_cnt, dwell, phase and hit counters = 0; sop_out, sop_missed, locked = 0.
- All outputs registered. sop_out rises 1 cycle after the qualifying sop_raw.
- phase counter: width clog2(PERIOD+WIN+1), cleared on each accepted SOP, +1 otherwise.
- Window condition: PERIOD-WIN <= phase <= PERIOD+WIN.
- en=0 in any state: IDLE on the next edge; locked=0, miss_cnt=0.
- IDLE:
  - thr_lvl <= thr_cfg every cycle.
  - en=1 -> SEARCH; dwell=0.
- SEARCH:
  - Each cycle with no sop_raw, dwell increments.
  - dwell==DWELL-1 with no SOP: thr_lvl <= max(thr_lvl-THR_STEP, THR_MIN); dwell=0.
  - sop_raw -> VERIFY; phase=0; hits=0. A SOP on the dwell-terminal cycle wins and no decrement occurs.
- VERIFY:
  - sop_raw inside the window: hits+1, phase=0. When hits reaches VERIFY_N -> TRACK, locked=1, miss_cnt=0.
  - sop_raw with phase < PERIOD-WIN (false alarm): thr_lvl <= thr_lvl+THR_STEP, saturating at 2^24-1; go to SEARCH; dwell=0.
  - phase passes PERIOD+WIN with no SOP: SEARCH, thr_lvl unchanged.
- TRACK:
  - sop_raw inside the window: sop_out pulse, phase=0, miss_cnt=0.
  - sop_raw outside the window: ignored; no pulse, phase keeps counting.
  - phase==PERIOD+WIN with no SOP on that cycle: sop_missed pulse, phase=WIN (re-centres on the nominal instant), miss_cnt+1.
  - miss_cnt reaching MISS_MAX: go to SEARCH; locked=0; thr_lvl <= thr_cfg; miss_cnt=0.
  - SOP exactly at phase==PERIOD+WIN counts as a hit, not a miss.
- thr_cfg changes are only sampled in IDLE and on loss of lock.

Test Plan:
Use PERIOD=100, WIN=4, VERIFY_N=3, MISS_MAX=2, DWELL=250, THR_STEP=10, THR_MIN=20.
- Reset/IDLE: assert rst=0 mid-stream -> all outputs 0 immediately. Release with en=0, thr_cfg=100 -> thr_lvl=100 one cycle later, state=0.
- Search ramp: en=1, no SOPs -> thr_lvl 90 after 250 cycles, 80 after 500; saturates at 20 after the 8th step and holds.
- Acquire: SOPs every 100 cycles -> first SOP gives state=2; the 3rd following SOP gives state=3, locked=1; subsequent SOPs produce sop_out one cycle later.
- Window edges in TRACK: SOPs at phase 96 and 104 -> sop_out. SOP at phase 95 -> no sop_out, phase unaffected. In VERIFY, a SOP at phase 95 -> state=1, thr_lvl+10.
- Loss: in TRACK stop SOPs -> sop_missed at phase 104, miss_cnt=1. Second miss 100 cycles later -> state=1, locked=0, thr_lvl=thr_cfg, miss_cnt=0.
- Enable drop: en=0 during TRACK -> state=0, locked=0 next cycle. Re-enable -> SEARCH starting from thr_cfg.
